// File: rtl/gf128_clmul_seq.sv
// Digit-serial 128x128 carry-less multiplier (MSB-first Horner), unreduced 256-bit product.
// Optional macro GF128_CLMUL_EARLY_EXIT_EN: zero operands skip straight to DONE.
module gf128_clmul_seq #(
  parameter int DIGIT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] a,
  input  logic [127:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out,
  output logic         busy
);

  localparam int N  = 128 / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic [127:0]   a_q;
  logic [127:0]   b_q;
  logic [255:0]   acc_q;
  logic [255:0]   acc_d;
  logic [255:0]   out_q;
  logic [CW-1:0]  cnt_q;
  logic           out_valid_q;
  logic           busy_q;
  logic [DIGIT-1:0] digit;
  logic           zeroOp;
  logic           lastStep;

`ifdef GF128_CLMUL_EARLY_EXIT_EN
  assign zeroOp = (a == 128'd0) || (b == 128'd0);
`else
  assign zeroOp = 1'b0;
`endif

  assign lastStep = (cnt_q == CW'(N - 1));

  // b_q shifts left each step, so the next digit is always its top DIGIT bits.
  always_comb begin
    digit = b_q[127 -: DIGIT];
    acc_d = acc_q << DIGIT;
    for (int j = 0; j < DIGIT; j++) begin
      if (digit[j]) begin
        acc_d = acc_d ^ ({128'd0, a_q} << j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= zeroOp ? DONE : RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          b_q   <= b_q << DIGIT;
          if (lastStep) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          // First DONE cycle publishes the product; afterwards wait for the sink.
          if (!out_valid_q) begin
            out_q       <= acc_q;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gf128_clmul_seq.sv
// Scoreboard bench for gf128_clmul_seq: bit-serial reference model, latency and handshake checks.
// Honours GF128_CLMUL_EARLY_EXIT_EN for the zero-operand latency.
module tb_gf128_clmul_seq;

  localparam int DIGIT = 8;
  localparam int N     = 128 / DIGIT;
`ifdef GF128_CLMUL_EARLY_EXIT_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = N + 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] a;
  logic [127:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out;
  logic         busy;

  int           testsRun;
  int           failCount;
  logic [255:0] expQ[$];
  logic [255:0] lastOut;

  gf128_clmul_seq #(.DIGIT(DIGIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] refClmul(input logic [127:0] x, input logic [127:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 128; i++) begin
      if (y[i]) r = r ^ ({128'd0, x} << i);
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Waits for in_ready, presents one pair for one edge, then scrambles a/b to prove they were latched.
  task automatic applyStimulus(input logic [127:0] x, input logic [127:0] y);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("acceptReady", 256'(in_ready), 256'(1));
    in_valid = 1'b1;
    a = x;
    b = y;
    expQ.push_back(refClmul(x, y));
    @(negedge clk);
    in_valid = 1'b0;
    a = rand128();
    b = rand128();
  endtask

  task automatic runOp(input logic [127:0] x, input logic [127:0] y, input int expLat, input int hold);
    int           lat;
    logic         sawReady;
    logic         stable;
    logic [255:0] held;
    logic [255:0] expv;
    applyStimulus(x, y);
    lat = 0;
    sawReady = 1'b0;
    while (!out_valid && lat < 4 * N + 20) begin
      if (in_ready || !busy) sawReady = 1'b1;
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 256'(lat), 256'(expLat));
    checkOutput("readyLowBusyHigh", 256'(sawReady), 256'(0));
    expv = (expQ.size() > 0) ? expQ.pop_front() : '0;
    checkOutput("product", out, expv);
    checkOutput("msbZero", 256'(out[255]), 256'(0));
    lastOut = out;
    held = out;
    stable = 1'b1;
    repeat (hold) begin
      out_ready = 1'b0;
      @(negedge clk);
      if (out !== held || !out_valid || in_ready) stable = 1'b0;
    end
    if (hold > 0) checkOutput("holdStable", 256'(stable), 256'(1));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("handoff", 256'({out_valid, in_ready, busy}), 256'(3'b010));
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetFlags", 256'({out_valid, busy, in_ready}), 256'(3'b001));
    checkOutput("resetOut", out, 256'd0);
    rst_n = 1'b1;

    runOp(128'd1, 128'd1, N + 1, 0);
    checkOutput("oneTimesOne", lastOut, 256'h1);
    runOp(128'd3, 128'd3, N + 1, 0);
    checkOutput("threeSquared", lastOut, 256'h5);
    runOp({128{1'b1}}, 128'd3, N + 1, 0);
    checkOutput("onesTimesThree", lastOut, (256'd1 << 128) | 256'd1);
    runOp(128'd1 << 127, 128'd1 << 127, N + 1, 5);
    checkOutput("topDegree", lastOut, 256'd1 << 254);
    runOp(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 128'd0, ZERO_LAT, 0);
    checkOutput("zeroB", lastOut, 256'd0);
    runOp(128'd0, 128'hdead_beef, ZERO_LAT, 0);
    checkOutput("zeroA", lastOut, 256'd0);

    // Abort an operation mid-RUN with in_valid asserted through the reset edge.
    applyStimulus(128'd3, 128'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("midRunResetFlags", 256'({out_valid, busy, in_ready}), 256'(3'b001));
    checkOutput("midRunResetOut", out, 256'd0);
    if (expQ.size() > 0) void'(expQ.pop_back());
    in_valid = 1'b0;
    rst_n = 1'b1;
    runOp(128'd3, 128'd3, N + 1, 0);
    checkOutput("afterReset", lastOut, 256'h5);

    for (int i = 0; i < 150; i++) begin
      runOp(rand128(), rand128(), N + 1, (i % 7 == 0) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
